// File: rtl/rename_commit_queue_pkg.sv
// Shared constants and entry layout for the rename commit queue.
package rename_commit_queue_pkg;

  // Default physical-name width; matches the rename file's default.
  localparam int NAME_W = 1;

  // Default log2 of the queue depth.
  localparam int IDX_W = 2;

  // One queue slot: completion flag plus the physical name it tracks.
  typedef struct packed {
    logic              done;
    logic [NAME_W-1:0] name;
  } rcq_entry_t;

endpackage

// File: rtl/rename_commit_queue_done_match.sv
// Per-entry writeback match: flags every occupied slot whose name equals
// a valid writeback name on either port.
module rcq_done_match
  import rename_commit_queue_pkg::*;
#(
  parameter int name_width = NAME_W,
  parameter int idx_width  = IDX_W
) (
  input  logic [idx_width:0]                         HEAD,
  input  logic [idx_width:0]                         TAIL,
  input  logic [(1<<idx_width)-1:0][name_width-1:0]  NAMES,
  input  logic                                       DONE_E_1,
  input  logic [name_width-1:0]                      DONE_NAME_1,
  input  logic                                       DONE_E_2,
  input  logic [name_width-1:0]                      DONE_NAME_2,
  output logic [(1<<idx_width)-1:0]                  SET
);

  localparam int DEPTH = 1 << idx_width;

  logic [idx_width:0]   count;
  logic [idx_width-1:0] offset [DEPTH];
  logic [DEPTH-1:0]     occupied;

  // Occupancy uses the wrap-bit distance from head, so a full queue
  // (index bits equal, wrap bits differ) marks every slot occupied.
  always_comb begin
    count    = TAIL - HEAD;
    occupied = '0;
    SET      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset[i]   = idx_width'(i) - HEAD[idx_width-1:0];
      occupied[i] = ({1'b0, offset[i]} < count);
      SET[i]      = occupied[i] &
                    ((DONE_E_1 && (NAMES[i] == DONE_NAME_1)) ||
                     (DONE_E_2 && (NAMES[i] == DONE_NAME_2)));
    end
  end

endmodule

// File: rtl/rename_commit_queue.sv
// In-order retirement queue beside the rename file. Names are recorded at
// allocation, marked done at writeback and retired strictly in allocation
// order through the NAME_F/FE free port.
//
// Handshakes: a transfer happens on a cycle where the requester's enable and
// the queue's ready are both high. Enqueue fires on ENQ_E & ENQ_READY; retire
// fires on COMMIT_E & COMMIT_READY (reported as FE). An enable seen while
// ready is low is ignored and changes no state. Ready never depends on the
// enable of the same port.
module rename_commit_queue
  import rename_commit_queue_pkg::*;
#(
  parameter int name_width = NAME_W,
  parameter int idx_width  = IDX_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [name_width-1:0] ENQ_NAME,
  input  logic                  ENQ_E,
  output logic                  ENQ_READY,
  input  logic [name_width-1:0] DONE_NAME_1,
  input  logic                  DONE_E_1,
  input  logic [name_width-1:0] DONE_NAME_2,
  input  logic                  DONE_E_2,
  input  logic                  COMMIT_E,
  output logic                  COMMIT_READY,
  output logic [name_width-1:0] NAME_F,
  output logic                  FE,
  output logic [idx_width:0]    COUNT,
  output logic                  EMPTY
);

  localparam int DEPTH = 1 << idx_width;

  typedef struct packed {
    logic                  done;
    logic [name_width-1:0] name;
  } entry_t;

  entry_t                                entries [DEPTH];
  logic [idx_width:0]                    head;
  logic [idx_width:0]                    tail;
  logic [idx_width:0]                    count;
  logic [idx_width-1:0]                  head_idx;
  logic [idx_width-1:0]                  tail_idx;
  logic                                  full;
  logic                                  empty;
  logic                                  enq_fire;
  logic                                  commit_ready;
  logic [DEPTH-1:0][name_width-1:0]      names_flat;
  logic [DEPTH-1:0]                      done_set;

  // Pointer arithmetic: wrap bit distinguishes full from empty.
  always_comb begin
    head_idx     = head[idx_width-1:0];
    tail_idx     = tail[idx_width-1:0];
    count        = tail - head;
    empty        = (head == tail);
    full         = (head_idx == tail_idx) && (head[idx_width] != tail[idx_width]);
    enq_fire     = ENQ_E && !full;
    commit_ready = !empty && entries[head_idx].done;
  end

  // Flatten stored names for the match unit.
  always_comb begin
    names_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      names_flat[i] = entries[i].name;
    end
  end

  rcq_done_match #(
    .name_width (name_width),
    .idx_width  (idx_width)
  ) u_done_match (
    .HEAD        (head),
    .TAIL        (tail),
    .NAMES       (names_flat),
    .DONE_E_1    (DONE_E_1),
    .DONE_NAME_1 (DONE_NAME_1),
    .DONE_E_2    (DONE_E_2),
    .DONE_NAME_2 (DONE_NAME_2),
    .SET         (done_set)
  );

  // Advance tail on accepted enqueue and head on retire.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (enq_fire) begin
        tail <= tail + 1'b1;
      end
      if (commit_ready && COMMIT_E) begin
        head <= head + 1'b1;
      end
    end
  end

  // Slot update: a fresh enqueue always lands with done clear, so a
  // same-cycle writeback of the new name cannot mark it (the slot is not
  // yet occupied and the enqueue write wins anyway).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_fire && (tail_idx == idx_width'(i))) begin
          entries[i].done <= 1'b0;
          entries[i].name <= ENQ_NAME;
        end else if (done_set[i]) begin
          entries[i].done <= 1'b1;
        end
      end
    end
  end

  // Outputs are combinational from registered state plus COMMIT_E for FE;
  // no writeback bypass and no full bypass.
  always_comb begin
    ENQ_READY    = !full;
    COMMIT_READY = commit_ready;
    FE           = COMMIT_E && commit_ready;
    NAME_F       = empty ? '0 : entries[head_idx].name;
    COUNT        = count;
    EMPTY        = empty;
  end

endmodule

// File: tb/tb_rename_commit_queue.sv
// Bench for rename_commit_queue: reset, table-driven in-order retire and
// dual writeback, full/drop, same-cycle enqueue+writeback, random wrap run.
module tb_rename_commit_queue;

  localparam int NW    = 4;
  localparam int IW    = 2;
  localparam int DEPTH = 1 << IW;

  logic          CLK = 1'b0;
  logic          RST;
  logic [NW-1:0] ENQ_NAME;
  logic          ENQ_E;
  logic          ENQ_READY;
  logic [NW-1:0] DONE_NAME_1;
  logic          DONE_E_1;
  logic [NW-1:0] DONE_NAME_2;
  logic          DONE_E_2;
  logic          COMMIT_E;
  logic          COMMIT_READY;
  logic [NW-1:0] NAME_F;
  logic          FE;
  logic [IW:0]   COUNT;
  logic          EMPTY;

  rename_commit_queue #(.name_width(NW), .idx_width(IW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ENQ_NAME     (ENQ_NAME),
    .ENQ_E        (ENQ_E),
    .ENQ_READY    (ENQ_READY),
    .DONE_NAME_1  (DONE_NAME_1),
    .DONE_E_1     (DONE_E_1),
    .DONE_NAME_2  (DONE_NAME_2),
    .DONE_E_2     (DONE_E_2),
    .COMMIT_E     (COMMIT_E),
    .COMMIT_READY (COMMIT_READY),
    .NAME_F       (NAME_F),
    .FE           (FE),
    .COUNT        (COUNT),
    .EMPTY        (EMPTY)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Scoreboard: names in expected retire order.
  logic [NW-1:0] exp_q [$];

  // Reference model of queue contents.
  logic [NW-1:0] m_name [$];
  logic          m_done [$];

  typedef struct {
    logic          ee;
    logic [NW-1:0] en;
    logic          d1e;
    logic [NW-1:0] d1n;
    logic          d2e;
    logic [NW-1:0] d2n;
    logic          ce;
    int            x_count;
    logic          x_ready;
    logic          x_cr;
    logic          x_fe;
    logic [NW-1:0] x_nf;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(int ee, int en, int d1e, int d1n, int d2e, int d2n,
                              int ce, int xc, int xr, int xcr, int xfe, int xnf);
    vec_t v;
    v.ee = 1'(ee);  v.en = NW'(en);
    v.d1e = 1'(d1e); v.d1n = NW'(d1n);
    v.d2e = 1'(d2e); v.d2n = NW'(d2n);
    v.ce = 1'(ce);  v.x_count = xc;
    v.x_ready = 1'(xr); v.x_cr = 1'(xcr); v.x_fe = 1'(xfe); v.x_nf = NW'(xnf);
    return v;
  endfunction

  task automatic check(input string what, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", what, act, req, $time);
    end
  endtask

  task automatic drive(input logic ee, input logic [NW-1:0] en,
                       input logic d1e, input logic [NW-1:0] d1n,
                       input logic d2e, input logic [NW-1:0] d2n,
                       input logic ce);
    ENQ_E = ee; ENQ_NAME = en;
    DONE_E_1 = d1e; DONE_NAME_1 = d1n;
    DONE_E_2 = d2e; DONE_NAME_2 = d2n;
    COMMIT_E = ce;
  endtask

  // Pop the scoreboard whenever the DUT retires.
  task automatic sb_check();
    logic [NW-1:0] e;
    if (FE) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_fe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_name_f", int'(NAME_F), int'(e));
      end
    end
  endtask

  task automatic model_reset();
    m_name.delete();
    m_done.delete();
    exp_q.delete();
  endtask

  // One clock of stimulus checked against the model; returns model's FE.
  task automatic model_cycle(input logic ee, input logic [NW-1:0] en,
                             input logic d1e, input logic [NW-1:0] d1n,
                             input logic d2e, input logic [NW-1:0] d2n,
                             input logic ce, output logic fired);
    int   sz;
    logic x_ready, x_cr, x_fe;
    logic [NW-1:0] x_nf;
    drive(ee, en, d1e, d1n, d2e, d2n, ce);
    #1;
    sz      = m_name.size();
    x_ready = (sz < DEPTH);
    x_cr    = (sz > 0) && m_done[0];
    x_fe    = ce && x_cr;
    x_nf    = (sz > 0) ? m_name[0] : '0;
    check("m_count", int'(COUNT), sz);
    check("m_count_bound", int'(COUNT <= DEPTH), 1);
    check("m_empty", int'(EMPTY), int'(sz == 0));
    check("m_enq_ready", int'(ENQ_READY), int'(x_ready));
    check("m_commit_ready", int'(COMMIT_READY), int'(x_cr));
    check("m_fe", int'(FE), int'(x_fe));
    check("m_name_f", int'(NAME_F), int'(x_nf));
    sb_check();
    for (int i = 0; i < sz; i++) begin
      if ((d1e && m_name[i] == d1n) || (d2e && m_name[i] == d2n)) m_done[i] = 1'b1;
    end
    if (x_fe) begin
      void'(m_name.pop_front());
      void'(m_done.pop_front());
    end
    if (ee && x_ready) begin
      m_name.push_back(en);
      m_done.push_back(1'b0);
      exp_q.push_back(en);
    end
    fired = x_fe;
    @(posedge CLK); #1;
  endtask

  initial begin
    logic f;
    int   commits;
    int   sz;

    // Reset state
    RST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst_count", int'(COUNT), 0);
    check("rst_empty", int'(EMPTY), 1);
    check("rst_enq_ready", int'(ENQ_READY), 1);
    check("rst_commit_ready", int'(COMMIT_READY), 0);
    check("rst_fe", int'(FE), 0);
    check("rst_name_f", int'(NAME_F), 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Async reset with three entries queued
    model_cycle(1, 1, 0, 0, 0, 0, 0, f);
    model_cycle(1, 2, 0, 0, 0, 0, 0, f);
    model_cycle(1, 3, 1, 1, 0, 0, 0, f);
    drive(0, 0, 0, 0, 0, 0, 1);
    #1;
    check("t1_pre_count", int'(COUNT), 3);
    check("t1_pre_fe", int'(FE), 1);
    #1;
    RST = 1'b1;
    #1;
    check("t1_count", int'(COUNT), 0);
    check("t1_empty", int'(EMPTY), 1);
    check("t1_enq_ready", int'(ENQ_READY), 1);
    check("t1_fe", int'(FE), 0);
    check("t1_name_f", int'(NAME_F), 0);
    model_reset();
    #2;
    RST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK); #1;

    // In-order retire with out-of-order writeback, then dual writeback
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 3, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2));
    vecs.push_back(mk(1, 4, 1, 3, 0, 0, 0,  2, 1, 0, 0, 2));
    vecs.push_back(mk(0, 0, 1, 2, 0, 0, 1,  3, 1, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  3, 1, 1, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  2, 1, 1, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 4));
    vecs.push_back(mk(0, 0, 1, 4, 0, 0, 0,  1, 1, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 1, 1, 1, 4));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 6, 0, 0, 0, 0, 1,  1, 1, 0, 0, 5));
    vecs.push_back(mk(0, 0, 1, 5, 1, 6, 0,  2, 1, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  2, 1, 1, 1, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 1, 1, 1, 6));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ee, vecs[i].en, vecs[i].d1e, vecs[i].d1n,
            vecs[i].d2e, vecs[i].d2n, vecs[i].ce);
      #1;
      check($sformatf("v%0d_count", i), int'(COUNT), vecs[i].x_count);
      check($sformatf("v%0d_empty", i), int'(EMPTY), int'(vecs[i].x_count == 0));
      check($sformatf("v%0d_enq_ready", i), int'(ENQ_READY), int'(vecs[i].x_ready));
      check($sformatf("v%0d_commit_ready", i), int'(COMMIT_READY), int'(vecs[i].x_cr));
      check($sformatf("v%0d_fe", i), int'(FE), int'(vecs[i].x_fe));
      check($sformatf("v%0d_name_f", i), int'(NAME_F), int'(vecs[i].x_nf));
      sb_check();
      if (vecs[i].ee && vecs[i].x_ready) exp_q.push_back(vecs[i].en);
      @(posedge CLK); #1;
    end
    check("tbl_sb_empty", exp_q.size(), 0);

    // Full: enqueue dropped even with a same-cycle commit
    model_cycle(1, 10, 0, 0, 0, 0, 0, f);
    model_cycle(1, 11, 0, 0, 0, 0, 0, f);
    model_cycle(1, 12, 1, 10, 0, 0, 0, f);
    model_cycle(1, 13, 0, 0, 0, 0, 0, f);
    model_cycle(1, 7, 0, 0, 0, 0, 1, f);
    check("t3_commit_fired", int'(f), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("t3_count", int'(COUNT), 3);
    check("t3_name_f", int'(NAME_F), 11);
    model_cycle(0, 0, 1, 11, 1, 12, 0, f);
    model_cycle(0, 0, 1, 13, 0, 0, 1, f);
    model_cycle(0, 0, 0, 0, 0, 0, 1, f);
    model_cycle(0, 0, 0, 0, 0, 0, 1, f);
    check("t3_drained", int'(EMPTY), 1);

    // Same-cycle enqueue and writeback leave the new entry not done
    model_cycle(1, 9, 1, 9, 0, 0, 0, f);
    model_cycle(0, 0, 0, 0, 0, 0, 1, f);
    check("t5_no_early_commit", int'(f), 0);
    model_cycle(0, 0, 1, 9, 0, 0, 0, f);
    model_cycle(0, 0, 0, 0, 0, 0, 1, f);
    check("t5_commit_after_done", int'(f), 1);

    // Random run wrapping the pointers
    commits = 0;
    for (int c = 0; c < 400 && commits < 10; c++) begin
      logic [NW-1:0] dn1, dn2;
      sz  = m_name.size();
      dn1 = (sz > 0) ? m_name[$urandom_range(0, sz - 1)] : NW'($urandom_range(0, 15));
      dn2 = NW'($urandom_range(0, 15));
      model_cycle(1'($urandom_range(0, 1)), NW'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), dn1,
                  1'($urandom_range(0, 1)), dn2,
                  1'($urandom_range(0, 1)), f);
      if (f) commits++;
    end
    check("t6_commit_budget", int'(commits >= 10), 1);
    for (int c = 0; c < 40 && m_name.size() > 0; c++) begin
      model_cycle(0, 0, 1, m_name[0], 0, 0, 1, f);
    end
    check("t6_drained", int'(EMPTY), 1);
    check("t6_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
